// File: rtl/bus_memory_if.sv
// Memory bus bundle: CPU strobes, program-load port and the two byte streams.
// master drives the strobes and stream inputs; slave is the memory responder.
interface bus_memory_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
);
  logic              CS;
  logic              R_NW;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0] prog_data;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output CS, R_NW, addr, wdata, prog_we, prog_addr, prog_data,
           in_data, in_valid, out_ready,
    input  rdata, in_ready, out_data, out_valid
  );

  modport slave (
    input  CS, R_NW, addr, wdata, prog_we, prog_addr, prog_data,
           in_data, in_valid, out_ready,
    output rdata, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/bus_memory.sv
// 29-word RAM plus STATUS/IN/OUT window; rdata one cycle after CS read.
// Stream ports are valid/ready with registered flags; full FIFOs deassert ready.
module bus_memory_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [2:0]   count
);
  logic [W-1:0] mem [0:3];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;

  // Caller only pushes below 4 and pops above 0, so count stays in 0..4.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

module bus_memory #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic         clock,
  input  logic         n_reset,
  bus_memory_if.slave  bus
);
  localparam int                RAM_WORDS = 29;
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(29);
  localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(30);
  localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(31);

  logic [WORD_W-1:0] ram [0:RAM_WORDS-1];
  logic              ovf;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              in_push;
  logic              in_pop;
  logic              out_push;
  logic              out_pop;
  logic              out_drop;
  logic [2:0]        in_count;
  logic [2:0]        out_count;
  logic [WORD_W-1:0] in_head;

  assign cpu_rd   = bus.CS &  bus.R_NW;
  assign cpu_wr   = bus.CS & ~bus.R_NW;

  assign in_push  = bus.in_valid & bus.in_ready;
  assign in_pop   = cpu_rd & (bus.addr == A_IN) & (in_count != 3'd0);
  assign out_pop  = bus.out_valid & bus.out_ready;
  assign out_push = cpu_wr & (bus.addr == A_OUT) & (out_count != 3'd4);
  assign out_drop = cpu_wr & (bus.addr == A_OUT) & (out_count == 3'd4);

  assign bus.in_ready  = (in_count != 3'd4);
  assign bus.out_valid = (out_count != 3'd0);

  bus_memory_fifo #(.W(WORD_W)) u_in_fifo (
    .clock     (clock),
    .n_reset   (n_reset),
    .push      (in_push),
    .pop       (in_pop),
    .push_data (bus.in_data),
    .head      (in_head),
    .count     (in_count)
  );

  bus_memory_fifo #(.W(WORD_W)) u_out_fifo (
    .clock     (clock),
    .n_reset   (n_reset),
    .push      (out_push),
    .pop       (out_pop),
    .push_data (bus.wdata),
    .head      (bus.out_data),
    .count     (out_count)
  );

  // CPU access always beats a same-cycle program load.
  always_ff @(posedge clock) begin
    if (cpu_wr) begin
      if (bus.addr < ADDR_W'(RAM_WORDS)) ram[bus.addr] <= bus.wdata;
    end else if (bus.prog_we && !bus.CS && (bus.prog_addr < ADDR_W'(RAM_WORDS))) begin
      ram[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ovf <= 1'b0;
    end else if (out_drop) begin
      ovf <= 1'b1;
    end else if (cpu_wr && (bus.addr == A_STATUS)) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      bus.rdata <= '0;
    end else if (cpu_rd) begin
      case (bus.addr)
        A_STATUS: bus.rdata <= {{(WORD_W-3){1'b0}}, ovf, (out_count == 3'd4), (in_count != 3'd0)};
        A_IN:     bus.rdata <= (in_count != 3'd0) ? in_head : '0;
        A_OUT:    bus.rdata <= '0;
        default:  bus.rdata <= ram[bus.addr];
      endcase
    end
  end
endmodule

// File: tb/tb_bus_memory.sv
// Scoreboarded bench: stimulus queues expected read data and output bytes,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_bus_memory;
  logic clock   = 1'b0;
  logic n_reset = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  logic [7:0] rd_q[$];
  logic [7:0] out_q[$];
  bit   rd_pend = 1'b0;

  bus_memory_if #(.WORD_W(8), .ADDR_W(5)) bus ();

  bus_memory #(.WORD_W(8), .ADDR_W(5)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 after posedge, so at negedge both inputs and outputs are stable.
  always @(negedge clock) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
      else chk("rdata", {24'd0, bus.rdata}, {24'd0, rd_q.pop_front()});
    end
    rd_pend = n_reset && bus.CS && bus.R_NW;
    if (n_reset && bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) chk("out_unexpected", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
      else chk("out_data", {24'd0, bus.out_data}, {24'd0, out_q.pop_front()});
    end
  end

  task automatic op(input logic cs, input logic rnw, input logic [4:0] a, input logic [7:0] wd,
                    input logic pwe, input logic [4:0] pa, input logic [7:0] pd, input logic [7:0] exp_rd);
    @(posedge clock); #2;
    bus.CS = cs; bus.R_NW = rnw; bus.addr = a; bus.wdata = wd;
    bus.prog_we = pwe; bus.prog_addr = pa; bus.prog_data = pd;
    if (cs && rnw) rd_q.push_back(exp_rd);
    @(posedge clock); #2;
    bus.CS = 1'b0; bus.prog_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    op(1'b1, 1'b1, a, 8'h00, 1'b0, 5'd0, 8'h00, e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    op(1'b1, 1'b0, a, d, 1'b0, 5'd0, 8'h00, 8'h00);
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    op(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, a, d, 8'h00);
  endtask

  task automatic in_push(input logic [7:0] d);
    @(posedge clock); #2;
    bus.in_valid = 1'b1; bus.in_data = d;
    @(posedge clock); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_n);
    int n = 0;
    @(posedge clock); #2;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 20) begin
      @(posedge clock); #2;
      n++;
    end
    bus.out_ready = 1'b0;
    chk(name, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CS = 1'b0; bus.R_NW = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("reset_rdata", {24'd0, bus.rdata}, 32'h0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clock); n_reset = 1'b1;

    rd(5'd29, 8'h00);
    prog(5'd3, 8'h55);
    rd(5'd3, 8'h55);
    // Load coinciding with a CPU read is dropped.
    op(1'b1, 1'b1, 5'd3, 8'h00, 1'b1, 5'd3, 8'hEE, 8'h55);
    rd(5'd3, 8'h55);
    prog(5'd30, 8'hFF);
    rd(5'd29, 8'h00);
    wr(5'd10, 8'hA7);
    rd(5'd10, 8'hA7);

    // Input FIFO fill, overfill, drain, underflow.
    in_push(8'h11); in_push(8'h22); in_push(8'h33); in_push(8'h44);
    chk("in_full_ready", {31'd0, bus.in_ready}, 32'd0);
    in_push(8'h66);
    rd(5'd29, 8'h01);
    rd(5'd30, 8'h11); rd(5'd30, 8'h22); rd(5'd30, 8'h33); rd(5'd30, 8'h44);
    rd(5'd30, 8'h00);
    chk("in_empty_ready", {31'd0, bus.in_ready}, 32'd1);
    rd(5'd31, 8'h00);

    // Output overflow: fifth write dropped, ovf set.
    for (int i = 1; i <= 5; i++) begin
      wr(5'd31, 8'(i));
      if (i <= 4) out_q.push_back(8'(i));
    end
    rd(5'd29, 8'h06);
    drain("drain_after_ovf", 4);
    rd(5'd29, 8'h04);
    wr(5'd29, 8'h5C);
    rd(5'd29, 8'h00);

    // Full output FIFO: pop and push on the same edge, push dropped.
    for (int i = 0; i < 4; i++) begin
      wr(5'd31, 8'hA1 + 8'(i));
      out_q.push_back(8'hA1 + 8'(i));
    end
    @(posedge clock); #2;
    bus.out_ready = 1'b1; bus.CS = 1'b1; bus.R_NW = 1'b0; bus.addr = 5'd31; bus.wdata = 8'h99;
    @(posedge clock); #2;
    bus.CS = 1'b0; bus.out_ready = 1'b0;
    rd(5'd29, 8'h04);
    drain("drain_after_full_pop_push", 3);
    wr(5'd29, 8'h00);

    // Not full: pop and push on the same edge, both happen.
    wr(5'd31, 8'hB1); out_q.push_back(8'hB1);
    wr(5'd31, 8'hB2); out_q.push_back(8'hB2);
    @(posedge clock); #2;
    bus.out_ready = 1'b1; bus.CS = 1'b1; bus.R_NW = 1'b0; bus.addr = 5'd31; bus.wdata = 8'h77;
    out_q.push_back(8'h77);
    @(posedge clock); #2;
    bus.CS = 1'b0; bus.out_ready = 1'b0;
    drain("drain_after_pop_push", 2);
    rd(5'd29, 8'h00);

    // Empty input FIFO: push and CPU read on the same edge.
    @(posedge clock); #2;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    bus.CS = 1'b1; bus.R_NW = 1'b1; bus.addr = 5'd30; rd_q.push_back(8'h00);
    @(posedge clock); #2;
    bus.CS = 1'b0; bus.in_valid = 1'b0;
    rd(5'd29, 8'h01);
    rd(5'd30, 8'h5A);
    rd(5'd30, 8'h00);

    // Non-empty input FIFO: push and pop together.
    in_push(8'h01);
    @(posedge clock); #2;
    bus.in_valid = 1'b1; bus.in_data = 8'h02;
    bus.CS = 1'b1; bus.R_NW = 1'b1; bus.addr = 5'd30; rd_q.push_back(8'h01);
    @(posedge clock); #2;
    bus.CS = 1'b0; bus.in_valid = 1'b0;
    rd(5'd30, 8'h02);
    rd(5'd30, 8'h00);

    // Reset mid-stream discards FIFO data but keeps RAM.
    in_push(8'hC1); in_push(8'hC2);
    wr(5'd31, 8'hD1); wr(5'd31, 8'hD2);
    rd(5'd10, 8'hA7);
    chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clock); #2;
    n_reset = 1'b0;
    #1;
    chk("midreset_rdata", {24'd0, bus.rdata}, 32'h0);
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clock); #2;
    n_reset = 1'b1;
    rd(5'd3, 8'h55);
    rd(5'd29, 8'h00);
    rd(5'd30, 8'h00);
    chk("post_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);

    repeat (3) @(posedge clock);
    #2;
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("out_q_empty", out_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_memory.md
# bus_memory

Memory-side responder for the basic processor's single-cycle memory bus. It answers the sequencer's CS/R_NW strobes, serving reads and writes from MAR/MDR, and holds a 29-word RAM plus a small memory-mapped I/O window. The window carries two 4-deep byte FIFOs that move ciphertext in and plaintext out between the CPU and the surrounding XOR-decryptor system. A side-band program-load port fills the RAM before or between CPU accesses.

## Interface
- WORD_W, 8, data word width
- ADDR_W, 5, address width (WORD_W - OP_W)
- clock  in  1  system clock, all state updates on rising edge
- n_reset  in  1  asynchronous, active-low reset
- CS  in  1  chip select from sequencer
- R_NW  in  1  1 = read, 0 = write (valid with CS)
- addr  in  ADDR_W  address from MAR
- wdata  in  WORD_W  write data from MDR
- rdata  out  WORD_W  registered read data to MDR
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  WORD_W  program-load data
- in_data  in  WORD_W  input byte stream
- in_valid  in  1  input byte present
- in_ready  out  1  input FIFO can accept
- out_data  out  WORD_W  head of output FIFO
- out_valid  out  1  output FIFO non-empty
- out_ready  in  1  consumer accepts out_data

## Operation
- Memory map: 0–28 RAM; 29 STATUS; 30 IN_DATA; 31 OUT_DATA.
- CPU read (CS=1, R_NW=1):
  - RAM address: rdata <= RAM[addr].
  - STATUS: rdata <= {0…0, ovf, out_full, in_nonempty}.
  - IN_DATA: if the input FIFO is non-empty, rdata <= head and the head is popped; if empty, rdata <= 0 and nothing is popped.
  - OUT_DATA: rdata <= 0.
- CPU write (CS=1, R_NW=0):
  - RAM address: RAM[addr] <= wdata.
  - STATUS: ovf <= 0 (any value).
  - IN_DATA: ignored.
  - OUT_DATA: push wdata if out count < 4; otherwise drop it and set ovf.
- CS=0: rdata holds its last value; no RAM, FIFO-pop or STATUS side effects.
- Program load: when prog_we=1 and CS=0, RAM[prog_addr] <= prog_data. If prog_addr ≥ 29, nothing happens. If prog_we=1 with CS=1, the load is dropped and the CPU access wins.
- Input FIFO: depth 4, circular 2-bit pointers plus a 3-bit count (0..4).
  - in_ready = (count < 4), combinational from registered count.
  - Push when in_valid & in_ready.
- Output FIFO: depth 4, same structure.
  - out_valid = (count > 0); out_data = head entry.
  - Pop when out_valid & out_ready.
- Simultaneous events (all decisions use pre-edge count):
  - Input push and CPU pop, non-empty: both occur, count unchanged.
  - Input push when empty with same-edge CPU read of IN_DATA: read returns 0, push occurs, count becomes 1.
  - Output pop and CPU push when full: push dropped, ovf set, pop occurs, count becomes 3.
  - Output pop and CPU push, not full: both occur.
  - Write to STATUS clears ovf; it is set again only by a later overflow.
- Pointers wrap modulo 4.

## Timing
- Reset (asynchronous on n_reset low):
  - rdata = 0, ovf = 0, both FIFO counts and pointers = 0.
  - in_ready = 1, out_valid = 0, out_data = FIFO entry 0 (contents undefined).
- RAM contents are not reset. Reset mid-operation discards all FIFO data.
- Read latency is one cycle: CS/R_NW sampled at edge N, rdata valid after edge N and held until the next read. This matches the sequencer's fetch/operand states, where CS is asserted in one state and MDR is loaded in the next.
- Writes take effect at the edge where CS=1 and R_NW=0; a read of the same address on the next access returns the new value.
- FIFO flags update one edge after push or pop; there is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- Program load: prog-write 0x55 to address 3 with CS=0, then CPU read of address 3 → rdata=0x55 one cycle later. Repeat with CS=1 held → load dropped, RAM[3] unchanged.
- RAM write then read: CPU write 0xA7 to address 10, CPU read of address 10 → rdata=0xA7. Read STATUS after reset → rdata=0x00.
- Input FIFO: push 0x11, 0x22, 0x33, 0x44 → in_ready=0, STATUS bit0=1. Four CPU reads of address 30 → 0x11, 0x22, 0x33, 0x44, then a fifth read → 0x00 and in_ready=1.
- Output overflow: out_ready=0, CPU writes 1, 2, 3, 4, 5 to address 31 → STATUS=0x06. Set out_ready=1 → out_data 1, 2, 3, 4 on consecutive cycles. CPU write to address 29 → STATUS=0x00.
- Simultaneous events: output FIFO full with out_ready=1 and a CPU write of 0x99 on the same edge → count 3, ovf=1, 0x99 absent. Input FIFO empty with in_valid=1 and a CPU read of address 30 on the same edge → rdata=0, count=1.
- Reset mid-stream: two bytes in each FIFO, pull n_reset low between edges → in_ready=1, out_valid=0, rdata=0 immediately. RAM[3] still 0x55 after reset.
